// File: rtl/time_cnt_prog.sv
// Programmable time counter: prescaled up/down count to a programmable terminal,
// with parallel load, wrap-or-stop behaviour and a registered terminal tick.
module time_cnt_prog #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 1
) (
  input  logic             clock_i,
  input  logic             reset_start_i,
  input  logic             enable_i,
  input  logic             up_down_i,
  input  logic             wrap_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic [WIDTH-1:0] counter_o,
  output logic             tick_o,
  output logic             done_o
);

  localparam int unsigned PreW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(DIV - 1);

  logic [PreW-1:0]  pre_q, pre_d;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;

  logic advance;
  logic step;
  logic terminal;

  always_comb begin
    advance   = enable_i & ~done_q;
    step      = advance & (pre_q == PreLast);
    terminal  = up_down_i ? (counter_q >= limit_i) : (counter_q == '0);

    pre_d     = pre_q;
    counter_d = counter_q;
    tick_d    = 1'b0;
    done_d    = done_q;

    if (load_i) begin
      // Load discards any partial prescale and wins over a coincident terminal step.
      counter_d = load_value_i;
      pre_d     = '0;
      done_d    = 1'b0;
    end else if (advance) begin
      pre_d = step ? '0 : pre_q + 1'b1;
      if (step) begin
        if (terminal) begin
          tick_d = 1'b1;
          if (wrap_i) begin
            counter_d = up_down_i ? '0 : limit_i;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          counter_d = up_down_i ? counter_q + 1'b1 : counter_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_start_i) begin
      pre_q     <= '0;
      counter_q <= '0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      counter_q <= counter_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
    end
  end

  assign counter_o = counter_q;
  assign tick_o    = tick_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_time_cnt_prog.sv
// Directed bench for time_cnt_prog: three instances (DIV=1,3,4) share stimulus,
// each scenario checks the instance whose prescale ratio it targets.
module tb_time_cnt_prog;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up;
  logic       wrap;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] limit;

  logic [7:0] cnt1, cnt3, cnt4;
  logic       tick1, tick3, tick4;
  logic       done1, done3, done4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  time_cnt_prog #(.WIDTH(8), .DIV(1)) u_div1 (
    .clock_i(clk), .reset_start_i(rst), .enable_i(en), .up_down_i(up), .wrap_i(wrap),
    .load_i(load), .load_value_i(load_val), .limit_i(limit),
    .counter_o(cnt1), .tick_o(tick1), .done_o(done1)
  );

  time_cnt_prog #(.WIDTH(8), .DIV(3)) u_div3 (
    .clock_i(clk), .reset_start_i(rst), .enable_i(en), .up_down_i(up), .wrap_i(wrap),
    .load_i(load), .load_value_i(load_val), .limit_i(limit),
    .counter_o(cnt3), .tick_o(tick3), .done_o(done3)
  );

  time_cnt_prog #(.WIDTH(8), .DIV(4)) u_div4 (
    .clock_i(clk), .reset_start_i(rst), .enable_i(en), .up_down_i(up), .wrap_i(wrap),
    .load_i(load), .load_value_i(load_val), .limit_i(limit),
    .counter_o(cnt4), .tick_o(tick4), .done_o(done4)
  );

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after an edge; outputs are sampled at the same point.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  int exp_up[8]   = '{1, 2, 3, 4, 5, 0, 1, 2};
  int tick_up[8]  = '{0, 0, 0, 0, 0, 1, 0, 0};
  int exp_stp[4]  = '{1, 2, 3, 3};
  int tick_stp[4] = '{0, 0, 0, 1};
  int dn_seq[3]   = '{2, 1, 0};

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; wrap = 1'b1; load = 1'b0;
    load_val = 8'd0; limit = 8'd5;

    // Reset state
    cycle();
    cycle();
    check_eq("rst_counter", cnt1, 0);
    check_eq("rst_tick", tick1, 0);
    check_eq("rst_done", done1, 0);
    rst = 1'b0;

    // Up/wrap, limit=5, DIV=1, enabled from cycle 3
    cycle();
    cycle();
    check_eq("frozen_counter", cnt1, 0);
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check_eq($sformatf("upwrap_cnt[%0d]", i), cnt1, exp_up[i]);
      check_eq($sformatf("upwrap_tick[%0d]", i), tick1, tick_up[i]);
      check_eq($sformatf("upwrap_done[%0d]", i), done1, 0);
    end

    // Up/stop, limit=3
    rst = 1'b1;
    cycle();
    rst = 1'b0; wrap = 1'b0; limit = 8'd3;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_eq($sformatf("upstop_cnt[%0d]", i), cnt1, exp_stp[i]);
      check_eq($sformatf("upstop_tick[%0d]", i), tick1, tick_stp[i]);
    end
    check_eq("upstop_done_rise", done1, 1);
    wrap = 1'b1;  // toggling wrap must not release done
    for (int i = 0; i < 20; i++) begin
      cycle();
      check_eq($sformatf("held_cnt[%0d]", i), cnt1, 3);
      check_eq($sformatf("held_tick[%0d]", i), tick1, 0);
      check_eq($sformatf("held_done[%0d]", i), done1, 1);
    end
    wrap = 1'b0; load = 1'b1; load_val = 8'd1;
    cycle();
    load = 1'b0;
    check_eq("reload_cnt", cnt1, 1);
    check_eq("reload_done", done1, 0);
    check_eq("reload_tick", tick1, 0);
    cycle();
    check_eq("resume_cnt", cnt1, 2);

    // Down/wrap, DIV=4, limit=2
    up = 1'b0; wrap = 1'b1; limit = 8'd2; load = 1'b1; load_val = 8'd2;
    cycle();
    load = 1'b0;
    check_eq("dn_load_cnt", cnt4, 2);
    for (int k = 1; k <= 24; k++) begin
      cycle();
      check_eq($sformatf("dn_cnt[%0d]", k), cnt4, dn_seq[(k / 4) % 3]);
      check_eq($sformatf("dn_tick[%0d]", k), tick4, (k % 12 == 0) ? 1 : 0);
    end

    // Prescaler freeze, DIV=3
    rst = 1'b1;
    cycle();
    rst = 1'b0; up = 1'b1; wrap = 1'b1; limit = 8'd10;
    cycle();
    cycle();
    check_eq("pre_before_step", cnt3, 0);
    cycle();
    check_eq("pre_first_step", cnt3, 1);
    cycle();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_eq($sformatf("frz_cnt[%0d]", i), cnt3, 1);
      check_eq($sformatf("frz_tick[%0d]", i), tick3, 0);
    end
    en = 1'b1;
    cycle();
    check_eq("resume_pre_cnt", cnt3, 1);
    cycle();
    check_eq("resume_step_cnt", cnt3, 2);
    check_eq("resume_step_tick", tick3, 0);

    // Boundary: limit=255 natural wrap, DIV=1
    limit = 8'd255; load = 1'b1; load_val = 8'd254;
    cycle();
    load = 1'b0;
    check_eq("b255_load", cnt1, 254);
    cycle();
    check_eq("b255_cnt", cnt1, 255);
    check_eq("b255_tick0", tick1, 0);
    cycle();
    check_eq("b255_wrap_cnt", cnt1, 0);
    check_eq("b255_wrap_tick", tick1, 1);

    // Boundary: counter above limit in up/stop is terminal on the next step
    limit = 8'd100; wrap = 1'b0; load = 1'b1; load_val = 8'd200;
    cycle();
    load = 1'b0;
    check_eq("over_load_cnt", cnt1, 200);
    cycle();
    check_eq("over_cnt", cnt1, 200);
    check_eq("over_done", done1, 1);
    check_eq("over_tick", tick1, 1);
    cycle();
    check_eq("over_tick_drop", tick1, 0);

    // Reset together with load, while done is set
    rst = 1'b1; load = 1'b1; load_val = 8'd7;
    cycle();
    rst = 1'b0; load = 1'b0;
    check_eq("rstld_cnt", cnt1, 0);
    check_eq("rstld_done", done1, 0);

    // Load on the terminal-step edge
    wrap = 1'b1; limit = 8'd5; load = 1'b1; load_val = 8'd5;
    cycle();
    load_val = 8'd9;
    cycle();
    load = 1'b0;
    check_eq("ldterm_cnt", cnt1, 9);
    check_eq("ldterm_tick", tick1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
